csr_wr_arbiter: RTL and testbench
=================================

// Module: csr_wr_arbiter
// PURPOSE
//  Owns the single CSR register-file write port; shares it between the trap/interrupt
//  sequencer (clint: MEPC/MCAUSE/MSTATUS bursts) and EX-stage CSR instructions.
//  A trap burst is atomic. An EX write that arrives during a burst is parked in a
//  1-entry pending buffer and drained after the burst. Reads see in-flight data.
// PARAMETERS
//  CSR_AW    12  CSR address width
//  XLEN      64  CSR data width
//  LOCK_MAX  16  max cycles in S_LOCK before forced release (watchdog)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        synchronous, active-low reset
//  trap_we_i      in   1        trap sequencer write strobe
//  trap_addr_i    in   CSR_AW   trap write address
//  trap_data_i    in   XLEN     trap write data
//  trap_busy_i    in   1        trap sequencer not idle (burst in progress)
//  ex_we_i        in   1        EX CSR-instruction write request
//  ex_addr_i      in   CSR_AW   EX write address
//  ex_data_i      in   XLEN     EX write data
//  ex_kill_i      in   1        EX instruction squashed; discard its pending write
//  ex_stall_o     out  1        EX write not accepted this cycle; hold EX
//  csr_we_o       out  1        register-file write enable (registered)
//  csr_addr_o     out  CSR_AW   register-file write address (registered)
//  csr_data_o     out  XLEN     register-file write data (registered)
//  rd_addr_i      in   CSR_AW   CSR read address from EX
//  rd_data_i      in   XLEN     raw register-file read data
//  rd_data_o      out  XLEN     forwarded read data
//  collision_o    out  1        sticky: pending EX write dropped (address hit by trap)
//  lock_timeout_o out  1        sticky: watchdog fired
// BEHAVIOUR
//  Reset: all outputs 0; state S_IDLE; pending buffer empty; lock counter 0.
//  Latency: an accepted write appears on csr_*_o exactly 1 cycle later.
//  FSM (one-hot, 3 states):
//   S_IDLE : trap_we_i|trap_busy_i -> S_LOCK. Trap write issues.
//            A same-cycle ex_we_i goes to pending; no stall.
//            Otherwise ex_we_i issues directly; ex_stall_o=0.
//   S_LOCK : only trap writes issue. ex_we_i with pending empty -> captured; no stall.
//            ex_we_i with pending full -> ex_stall_o=1.
//            Trap write whose addr == pending addr -> pending dropped; collision_o set.
//            Exit when !trap_busy_i & !trap_we_i: -> S_DRAIN if pending valid, else S_IDLE.
//            Lock counter +1 per cycle in S_LOCK. At LOCK_MAX-1: force exit,
//            set lock_timeout_o, and ignore trap writes until trap_busy_i drops.
//   S_DRAIN: issue pending, clear it, ex_stall_o=1 on ex_we_i -> S_IDLE.
//            trap_we_i here: the trap write wins and the pending write stays -> S_LOCK.
//  Trap writes are never stalled or dropped (except after watchdog).
//  ex_kill_i: clears pending the same cycle (pending never issues). Has priority over
//  drain. A killed ex_we_i is not captured.
//  Forwarding: rd_data_o = pending hit ? pending data : (csr_we_o & csr_addr_o==rd_addr_i)
//  ? csr_data_o : rd_data_i. Pending has highest priority (it is applied last).
//  Sticky flags clear only on reset. Reset mid-burst: pending lost; no write issued.
// STRUCTURE
//  Shared package (define.v): CSR_AW/XLEN widths, CSR_MEPC/CSR_MCAUSE/CSR_MSTATUS,
//  WriteEnable/WriteDisable, state encodings S_ARB_IDLE/S_ARB_LOCK/S_ARB_DRAIN.
//  One natural sub-module: csr_pend_buf (1-entry valid/addr/data register with
//  capture, kill, drop-on-match, drain and compare-for-forward).
// TESTING
//  1 IDLE, ex_we_i addr 0x340 data 0x5A -> next cycle csr_we_o=1, addr 0x340, data 0x5A;
//    ex_stall_o=0.
//  2 Trap burst MEPC/MCAUSE/MSTATUS. ex_we_i 0x340 in cycle 1 -> pending captured.
//    Writes out in order 0x341,0x342,0x300, then 0x340; second ex_we_i in lock stalls.
//  3 Pending 0x300 while trap writes 0x300 -> pending dropped; collision_o=1;
//    no drain cycle; back to S_IDLE.
//  4 Pending 0x340=0x77; rd_addr_i=0x340, rd_data_i=0x11 -> rd_data_o=0x77.
//    After drain and write, rd_data_o = rd_data_i.
//  5 trap_busy_i held high 20 cycles -> lock_timeout_o=1 at cycle 16; pending drains.
//  6 ex_kill_i with pending valid -> no drain write. Reset asserted in S_LOCK ->
//    all outputs 0 next cycle.

Source files
------------

// File: rtl/csr_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// csr_wr_arbiter_pkg
// Shared definitions for the CSR write-port arbiter:
//   - default CSR address/data widths and watchdog depth
//   - machine-mode CSR addresses touched by the trap sequencer
//   - write-enable constants
//   - one-hot arbiter state encoding
// -----------------------------------------------------------------------------
package csr_wr_arbiter_pkg;

  localparam int DEF_CSR_AW   = 12;
  localparam int DEF_XLEN     = 64;
  localparam int DEF_LOCK_MAX = 16;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  typedef enum logic [2:0] {
    S_ARB_IDLE  = 3'b001,
    S_ARB_LOCK  = 3'b010,
    S_ARB_DRAIN = 3'b100
  } arb_state_e;

endpackage

// File: rtl/csr_wr_arbiter_pend.sv
// -----------------------------------------------------------------------------
// csr_pend_buf
// One-entry parking slot for an EX-stage CSR write that arrives while a trap
// burst owns the register-file write port.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (clears valid only)
//   i_capture      load i_cap_addr/i_cap_data and mark valid
//   i_clear        invalidate the entry (kill, drain or trap address hit);
//                  wins over i_capture
//   i_cap_addr     address to park
//   i_cap_data     data to park
//   i_trap_addr    address of the trap write issuing this cycle
//   i_rd_addr      EX read address, for forwarding
//   o_vld          entry holds a write
//   o_addr/o_data  parked write
//   o_trap_hit     valid entry targets the same CSR as the trap write
//   o_rd_hit       valid entry targets the CSR being read
// -----------------------------------------------------------------------------
module csr_pend_buf
  import csr_wr_arbiter_pkg::*;
#(
  parameter int CSR_AW = DEF_CSR_AW,
  parameter int XLEN   = DEF_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture,
  input  logic              i_clear,
  input  logic [CSR_AW-1:0] i_cap_addr,
  input  logic [XLEN-1:0]   i_cap_data,
  input  logic [CSR_AW-1:0] i_trap_addr,
  input  logic [CSR_AW-1:0] i_rd_addr,
  output logic              o_vld,
  output logic [CSR_AW-1:0] o_addr,
  output logic [XLEN-1:0]   o_data,
  output logic              o_trap_hit,
  output logic              o_rd_hit
);

  logic              r_vld;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
    end else if (i_clear) begin
      r_vld <= 1'b0;
    end else if (i_capture) begin
      r_vld <= 1'b1;
    end
  end

  // Payload carries no reset: it is only observed through r_vld.
  always_ff @(posedge clk) begin
    if (i_capture && !i_clear) begin
      r_addr <= i_cap_addr;
      r_data <= i_cap_data;
    end
  end

  assign o_vld      = r_vld;
  assign o_addr     = r_addr;
  assign o_data     = r_data;
  assign o_trap_hit = r_vld && (r_addr == i_trap_addr);
  assign o_rd_hit   = r_vld && (r_addr == i_rd_addr);

endmodule

// File: rtl/csr_wr_arbiter.sv
// -----------------------------------------------------------------------------
// csr_wr_arbiter
// Owns the single CSR register-file write port and shares it between the
// trap/interrupt sequencer and EX-stage CSR instructions. A trap burst is
// atomic; an EX write arriving during a burst is parked and drained after it.
// Read data is forwarded from the parked write and from the write in flight.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   trap_we_i/addr_i/data_i     trap sequencer write
//   trap_busy_i                 trap burst in progress
//   ex_we_i/addr_i/data_i       EX CSR-instruction write request
//   ex_kill_i                   EX instruction squashed
//   ex_stall_o                  EX write not accepted this cycle
//   csr_we_o/addr_o/data_o      registered register-file write port
//   rd_addr_i, rd_data_i        EX read address and raw register-file data
//   rd_data_o                   forwarded read data
//   collision_o                 sticky: parked write dropped by a trap hit
//   lock_timeout_o              sticky: lock watchdog fired
// -----------------------------------------------------------------------------
module csr_wr_arbiter
  import csr_wr_arbiter_pkg::*;
#(
  parameter int CSR_AW   = DEF_CSR_AW,
  parameter int XLEN     = DEF_XLEN,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trap_we_i,
  input  logic [CSR_AW-1:0] trap_addr_i,
  input  logic [XLEN-1:0]   trap_data_i,
  input  logic              trap_busy_i,
  input  logic              ex_we_i,
  input  logic [CSR_AW-1:0] ex_addr_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              ex_kill_i,
  output logic              ex_stall_o,
  output logic              csr_we_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_data_o,
  input  logic [CSR_AW-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   rd_data_i,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              collision_o,
  output logic              lock_timeout_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ign;
  logic              r_we;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_data;
  logic              r_coll;
  logic              r_tmo;

  logic              w_trap_we;
  logic              w_trap_busy;
  logic              w_ex_req;
  logic              w_issue;
  logic              w_capture;
  logic              w_pend_clr;
  logic              w_drop;
  logic              w_stall;
  logic              w_lock_to;
  logic              w_pend_vld_nxt;
  logic [CSR_AW-1:0] w_wr_addr;
  logic [XLEN-1:0]   w_wr_data;

  logic              w_pend_vld;
  logic [CSR_AW-1:0] w_pend_addr;
  logic [XLEN-1:0]   w_pend_data;
  logic              w_pend_trap_hit;
  logic              w_pend_rd_hit;

  // After the watchdog fires, the trap sequencer is ignored until it drops
  // busy, so a stuck sequencer cannot immediately re-lock the port.
  assign w_trap_we   = trap_we_i   & ~r_ign;
  assign w_trap_busy = trap_busy_i & ~r_ign;
  // A squashed EX write is never issued nor parked.
  assign w_ex_req    = ex_we_i & ~ex_kill_i;

  assign w_lock_to = (r_state == S_ARB_LOCK) && (r_cnt == CNT_W'(LOCK_MAX - 1));

  always_comb begin
    w_issue    = 1'b0;
    w_capture  = 1'b0;
    w_pend_clr = ex_kill_i;
    w_drop     = 1'b0;
    w_stall    = 1'b0;
    w_wr_addr  = trap_addr_i;
    w_wr_data  = trap_data_i;
    case (r_state)
      S_ARB_IDLE: begin
        if (w_trap_we || w_trap_busy) begin
          // Burst starts: trap takes the port, a same-cycle EX write is parked.
          w_issue   = w_trap_we;
          w_capture = w_ex_req;
        end else if (w_ex_req) begin
          w_issue   = 1'b1;
          w_wr_addr = ex_addr_i;
          w_wr_data = ex_data_i;
        end
      end
      S_ARB_LOCK: begin
        w_issue   = w_trap_we;
        w_capture = w_ex_req & ~w_pend_vld;
        w_stall   = w_ex_req & w_pend_vld;
        // Trap overwrites the CSR the parked write targets: the parked value
        // is stale relative to the trap, so it is discarded.
        w_drop    = w_trap_we & w_pend_trap_hit & ~ex_kill_i;
      end
      S_ARB_DRAIN: begin
        w_stall = w_ex_req;
        if (w_trap_we) begin
          // New burst wins the port; the parked write waits for it.
          w_issue = 1'b1;
          w_drop  = w_pend_trap_hit & ~ex_kill_i;
        end else if (!ex_kill_i) begin
          w_issue    = w_pend_vld;
          w_wr_addr  = w_pend_addr;
          w_wr_data  = w_pend_data;
          w_pend_clr = 1'b1;
        end
      end
      default: begin
        w_issue = 1'b0;
      end
    endcase
    w_pend_clr = w_pend_clr | w_drop;
  end

  assign w_pend_vld_nxt = w_capture | (w_pend_vld & ~w_pend_clr);

  csr_pend_buf #(
    .CSR_AW (CSR_AW),
    .XLEN   (XLEN)
  ) u_pend (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_capture   (w_capture),
    .i_clear     (w_pend_clr),
    .i_cap_addr  (ex_addr_i),
    .i_cap_data  (ex_data_i),
    .i_trap_addr (trap_addr_i),
    .i_rd_addr   (rd_addr_i),
    .o_vld       (w_pend_vld),
    .o_addr      (w_pend_addr),
    .o_data      (w_pend_data),
    .o_trap_hit  (w_pend_trap_hit),
    .o_rd_hit    (w_pend_rd_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_ARB_IDLE;
      r_cnt   <= '0;
      r_ign   <= 1'b0;
      r_we    <= WriteDisable;
      r_addr  <= '0;
      r_data  <= '0;
      r_coll  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_we <= w_issue ? WriteEnable : WriteDisable;
      if (w_issue) begin
        r_addr <= w_wr_addr;
        r_data <= w_wr_data;
      end
      if (w_drop) begin
        r_coll <= 1'b1;
      end
      if (!trap_busy_i) begin
        r_ign <= 1'b0;
      end
      case (r_state)
        S_ARB_IDLE: begin
          r_cnt <= '0;
          if (w_trap_we || w_trap_busy) begin
            r_state <= S_ARB_LOCK;
          end
        end
        S_ARB_LOCK: begin
          if (w_lock_to) begin
            r_tmo   <= 1'b1;
            r_ign   <= 1'b1;
            r_cnt   <= '0;
            r_state <= w_pend_vld_nxt ? S_ARB_DRAIN : S_ARB_IDLE;
          end else if (!w_trap_we && !w_trap_busy) begin
            r_cnt   <= '0;
            r_state <= w_pend_vld_nxt ? S_ARB_DRAIN : S_ARB_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ARB_DRAIN: begin
          r_cnt   <= '0;
          r_state <= w_trap_we ? S_ARB_LOCK : S_ARB_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_ARB_IDLE;
        end
      endcase
    end
  end

  assign ex_stall_o     = w_stall;
  assign csr_we_o       = r_we;
  assign csr_addr_o     = r_addr;
  assign csr_data_o     = r_data;
  assign collision_o    = r_coll;
  assign lock_timeout_o = r_tmo;

  // The parked write is newer than anything in flight, so it is checked first.
  assign rd_data_o = w_pend_rd_hit                  ? w_pend_data :
                     (r_we && (r_addr == rd_addr_i)) ? r_data      :
                                                       rd_data_i;

endmodule

// File: tb/tb_csr_wr_arbiter.sv
module tb_csr_wr_arbiter;
  import csr_wr_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 64;
  localparam int LM = 16;
  localparam logic [11:0] NOA  = 12'h7FF;
  localparam logic [63:0] DEAD = 64'hDEAD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          trap_we_i;
  logic [AW-1:0] trap_addr_i;
  logic [DW-1:0] trap_data_i;
  logic          trap_busy_i;
  logic          ex_we_i;
  logic [AW-1:0] ex_addr_i;
  logic [DW-1:0] ex_data_i;
  logic          ex_kill_i;
  logic          ex_stall_o;
  logic          csr_we_o;
  logic [AW-1:0] csr_addr_o;
  logic [DW-1:0] csr_data_o;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_i;
  logic [DW-1:0] rd_data_o;
  logic          collision_o;
  logic          lock_timeout_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_wr_arbiter #(
    .CSR_AW   (AW),
    .XLEN     (DW),
    .LOCK_MAX (LM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap_we_i      (trap_we_i),
    .trap_addr_i    (trap_addr_i),
    .trap_data_i    (trap_data_i),
    .trap_busy_i    (trap_busy_i),
    .ex_we_i        (ex_we_i),
    .ex_addr_i      (ex_addr_i),
    .ex_data_i      (ex_data_i),
    .ex_kill_i      (ex_kill_i),
    .ex_stall_o     (ex_stall_o),
    .csr_we_o       (csr_we_o),
    .csr_addr_o     (csr_addr_o),
    .csr_data_o     (csr_data_o),
    .rd_addr_i      (rd_addr_i),
    .rd_data_i      (rd_data_i),
    .rd_data_o      (rd_data_o),
    .collision_o    (collision_o),
    .lock_timeout_o (lock_timeout_o)
  );

  typedef struct {
    logic        twe;
    logic        tbusy;
    logic [11:0] taddr;
    logic [63:0] tdata;
    logic        ewe;
    logic [11:0] eaddr;
    logic [63:0] edata;
    logic        kill;
    logic [11:0] raddr;
    logic [63:0] rdat;
    logic        x_stall;
    logic [63:0] x_rd;
    logic        x_we;
    logic [11:0] x_addr;
    logic [63:0] x_data;
    logic        x_coll;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic twe, input logic tbusy, input logic [11:0] taddr,
                       input logic [63:0] tdata, input logic ewe, input logic [11:0] eaddr,
                       input logic [63:0] edata, input logic kill, input logic [11:0] raddr,
                       input logic [63:0] rdat);
    trap_we_i   = twe;
    trap_busy_i = tbusy;
    trap_addr_i = taddr;
    trap_data_i = tdata;
    ex_we_i     = ewe;
    ex_addr_i   = eaddr;
    ex_data_i   = edata;
    ex_kill_i   = kill;
    rd_addr_i   = raddr;
    rd_data_i   = rdat;
  endtask

  initial begin
    // Columns: trap we/busy/addr/data, ex we/addr/data, kill, rd addr/data,
    // then expected: stall and rd_data_o this cycle; we/addr/data/collision next cycle.
    // Simple EX write in idle.
    vecs[0]  = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h340, 64'h5A, 1'b0, NOA, DEAD,
                 1'b0, DEAD, 1'b1, 12'h340, 64'h5A, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h340, 64'h11,
                 1'b0, 64'h5A, 1'b0, 12'h000, 64'h0, 1'b0};
    // Trap burst MEPC/MCAUSE/MSTATUS with a parked EX write and a stalled second one.
    vecs[2]  = '{1'b1, 1'b1, CSR_MEPC, 64'h1000, 1'b1, 12'h340, 64'h77, 1'b0, NOA, DEAD,
                 1'b0, DEAD, 1'b1, CSR_MEPC, 64'h1000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, CSR_MCAUSE, 64'h2000, 1'b1, 12'h305, 64'h99, 1'b0, 12'h340, 64'h11,
                 1'b1, 64'h77, 1'b1, CSR_MCAUSE, 64'h2000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, CSR_MSTATUS, 64'h3000, 1'b1, 12'h305, 64'h99, 1'b0, CSR_MCAUSE, 64'h11,
                 1'b1, 64'h2000, 1'b1, CSR_MSTATUS, 64'h3000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h305, 64'h99, 1'b0, NOA, DEAD,
                 1'b1, DEAD, 1'b0, 12'h000, 64'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h305, 64'h99, 1'b0, 12'h340, 64'h11,
                 1'b1, 64'h77, 1'b1, 12'h340, 64'h77, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h305, 64'h99, 1'b0, 12'h340, 64'h11,
                 1'b0, 64'h77, 1'b1, 12'h305, 64'h99, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h340, 64'h11,
                 1'b0, 64'h11, 1'b0, 12'h000, 64'h0, 1'b0};
    // Parked write to MSTATUS hit by a trap write to MSTATUS: dropped, no drain.
    vecs[9]  = '{1'b1, 1'b1, CSR_MEPC, 64'hA, 1'b1, CSR_MSTATUS, 64'h55, 1'b0, NOA, DEAD,
                 1'b0, DEAD, 1'b1, CSR_MEPC, 64'hA, 1'b0};
    vecs[10] = '{1'b1, 1'b1, CSR_MSTATUS, 64'hB, 1'b0, 12'h000, 64'h0, 1'b0, CSR_MSTATUS, 64'h11,
                 1'b0, 64'h55, 1'b1, CSR_MSTATUS, 64'hB, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h0, 1'b0, CSR_MSTATUS, 64'h11,
                 1'b0, 64'hB, 1'b0, 12'h000, 64'h0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h344, 64'h3, 1'b0, NOA, DEAD,
                 1'b0, DEAD, 1'b1, 12'h344, 64'h3, 1'b1};
    // Kill of a parked write: no drain follows.
    vecs[13] = '{1'b1, 1'b1, CSR_MCAUSE, 64'hC, 1'b1, 12'h340, 64'h66, 1'b0, NOA, DEAD,
                 1'b0, DEAD, 1'b1, CSR_MCAUSE, 64'hC, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 12'h000, 64'h0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h340, 64'h11,
                 1'b0, 64'h66, 1'b0, 12'h000, 64'h0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h000, 64'h0, 1'b0, 12'h340, 64'h11,
                 1'b0, 64'h11, 1'b0, 12'h000, 64'h0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h345, 64'h4, 1'b0, NOA, DEAD,
                 1'b0, DEAD, 1'b1, 12'h345, 64'h4, 1'b1};
    // Killed EX write in idle is not issued.
    vecs[17] = '{1'b0, 1'b0, 12'h000, 64'h0, 1'b1, 12'h346, 64'h5, 1'b1, 12'h345, 64'h11,
                 1'b0, 64'h4, 1'b0, 12'h000, 64'h0, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0);
    repeat (3) step();
    chk("rst.we", 64'(csr_we_o), 64'h0);
    chk("rst.addr", 64'(csr_addr_o), 64'h0);
    chk("rst.data", csr_data_o, 64'h0);
    chk("rst.stall", 64'(ex_stall_o), 64'h0);
    chk("rst.coll", 64'(collision_o), 64'h0);
    chk("rst.tmo", 64'(lock_timeout_o), 64'h0);
    chk("rst.rd", rd_data_o, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].twe, vecs[i].tbusy, vecs[i].taddr, vecs[i].tdata, vecs[i].ewe,
            vecs[i].eaddr, vecs[i].edata, vecs[i].kill, vecs[i].raddr, vecs[i].rdat);
      #2;
      chk($sformatf("v%0d.stall", i), 64'(ex_stall_o), 64'(vecs[i].x_stall));
      chk($sformatf("v%0d.rd", i), rd_data_o, vecs[i].x_rd);
      step();
      chk($sformatf("v%0d.we", i), 64'(csr_we_o), 64'(vecs[i].x_we));
      if (vecs[i].x_we) begin
        chk($sformatf("v%0d.addr", i), 64'(csr_addr_o), 64'(vecs[i].x_addr));
        chk($sformatf("v%0d.data", i), csr_data_o, vecs[i].x_data);
      end
      chk($sformatf("v%0d.coll", i), 64'(collision_o), 64'(vecs[i].x_coll));
      chk($sformatf("v%0d.tmo", i), 64'(lock_timeout_o), 64'h0);
    end

    // Watchdog: busy stuck high; the 16th cycle in lock forces release and the
    // parked write drains while the sequencer is still busy.
    drive(1'b1, 1'b1, CSR_MEPC, 64'hE, 1'b1, 12'h347, 64'h88, 1'b0, NOA, DEAD);
    step();
    chk("wd.first_we", 64'(csr_we_o), 64'h1);
    drive(1'b0, 1'b1, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0, 1'b0, NOA, DEAD);
    for (int c = 2; c <= LM; c++) begin
      step();
      chk($sformatf("wd.c%0d.tmo", c), 64'(lock_timeout_o), 64'h0);
      chk($sformatf("wd.c%0d.we", c), 64'(csr_we_o), 64'h0);
    end
    step();
    chk("wd.fire.tmo", 64'(lock_timeout_o), 64'h1);
    chk("wd.fire.we", 64'(csr_we_o), 64'h0);
    step();
    chk("wd.drain.we", 64'(csr_we_o), 64'h1);
    chk("wd.drain.addr", 64'(csr_addr_o), 64'h347);
    chk("wd.drain.data", csr_data_o, 64'h88);
    // Trap writes are ignored until busy drops.
    drive(1'b1, 1'b1, CSR_MSTATUS, 64'hF, 1'b0, 12'h0, 64'h0, 1'b0, NOA, DEAD);
    step();
    chk("wd.ignored.we", 64'(csr_we_o), 64'h0);
    drive(1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0, 1'b0, NOA, DEAD);
    step();
    chk("wd.release.we", 64'(csr_we_o), 64'h0);
    drive(1'b1, 1'b1, CSR_MSTATUS, 64'hF, 1'b1, 12'h340, 64'h66, 1'b0, NOA, DEAD);
    step();
    chk("wd.rearm.we", 64'(csr_we_o), 64'h1);
    chk("wd.rearm.addr", 64'(csr_addr_o), 64'(CSR_MSTATUS));
    chk("wd.sticky.tmo", 64'(lock_timeout_o), 64'h1);

    // Reset while locked with a parked write: everything cleared, nothing drains.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, CSR_MEPC, 64'h1, 1'b1, 12'h340, 64'h66, 1'b0, 12'h340, 64'h0);
    step();
    chk("rl.we", 64'(csr_we_o), 64'h0);
    chk("rl.addr", 64'(csr_addr_o), 64'h0);
    chk("rl.data", csr_data_o, 64'h0);
    chk("rl.stall", 64'(ex_stall_o), 64'h0);
    chk("rl.coll", 64'(collision_o), 64'h0);
    chk("rl.tmo", 64'(lock_timeout_o), 64'h0);
    chk("rl.rd", rd_data_o, 64'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h340, 64'h0);
    step();
    chk("rl.post1.we", 64'(csr_we_o), 64'h0);
    step();
    chk("rl.post2.we", 64'(csr_we_o), 64'h0);
    chk("rl.post2.rd", rd_data_o, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
